ftdi_status_tx: RTL and testbench

FTDI_STATUS_TX -- requirements
Module: ftdi_status_tx

---
 rtl/ftdi_status_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_ftdi_status_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_status_tx.sv
// ---------------------------------------------------------------------------
// ftdi_status_tx
//
// Sends a 4-byte status frame to an FTDI FT245-style synchronous FIFO
// whenever the combined 12-bit status snapshot changes. The status inputs
// come from the CLK_25M domain. Each bit is synchronised into the FTDI clock
// domain, and a value is used only after it has been seen on two consecutive
// cycles.
//
// Frame: B0 = HEADER, B1 = {4'h0, controlstate}, B2 = {psPot_state,
//        SGclock_state}, B3 = B0 ^ B1 ^ B2. A send-immediate pulse follows
//        the frame.
//
// Parameters
//   HEADER        first byte of every frame
//   TIMEOUT       consecutive stalled SEND cycles before the frame is dropped
//
// Ports
//   clk           FTDI_CLK (60 MHz), sole clock
//   reset_n       asynchronous active-low reset
//   controlstate  top-level FSM state   (CLK_25M domain)
//   psPot_state   psPot state           (CLK_25M domain)
//   SGclock_state SGclock state         (CLK_25M domain)
//   rx_busy       receive path owns DATA_BUS; no new frame is started while high
//   TXEn          FTDI TX FIFO not-full, active-low
//   data_out      byte driven onto DATA_BUS
//   data_oe       DATA_BUS drive enable, high = drive
//   wr_n          FTDI write strobe, active-low, registered
//   siwu_n        FTDI send-immediate, active-low
//   oe_n          FTDI read output enable, held high
//   busy          high from LOAD through FLUSH
//   tx_drop       one-cycle pulse when a stalled frame is abandoned
//   frames_sent   completed frame count, wraps at 8 bits
// ---------------------------------------------------------------------------
module ftdi_status_tx #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd60000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] controlstate,
    input  logic [3:0] psPot_state,
    input  logic [3:0] SGclock_state,
    input  logic       rx_busy,
    input  logic       TXEn,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       wr_n,
    output logic       siwu_n,
    output logic       oe_n,
    output logic       busy,
    output logic       tx_drop,
    output logic [7:0] frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FLUSH
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] s_meta;     // first synchroniser stage
    logic [11:0] s_sync;     // second synchroniser stage
    logic [11:0] s_prev;     // s_sync delayed one cycle, for the stability test
    logic [2:0]  s_vld;      // marks stages that hold post-reset samples
    logic [11:0] s_stable;   // newest value seen on two consecutive cycles
    logic [11:0] last_sent;  // snapshot carried by the most recent LOAD
    logic        pending;

    logic [7:0]  frame_b [4];
    logic [1:0]  byte_idx;
    logic [15:0] stall_cnt;

    logic        accept;
    logic        last_byte;
    logic        stall_hit;

    // A byte is accepted on the edge where the strobe and FIFO-ready are both low.
    assign accept    = (state == ST_SEND) && !wr_n && !TXEn;
    assign last_byte = accept && (byte_idx == 2'd3);
    // This is the TIMEOUT-th consecutive stalled cycle.
    assign stall_hit = (state == ST_SEND) && TXEn && (stall_cnt == TIMEOUT - 16'd1);

    // -----------------------------------------------------------------------
    // Synchroniser and stability filter
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_meta   <= 12'h000;
            s_sync   <= 12'h000;
            s_prev   <= 12'h000;
            s_vld    <= 3'b000;
            // Matches last_sent, so no frame is requested before real samples arrive.
            s_stable <= 12'hFFF;
        end else begin
            s_meta <= {controlstate, psPot_state, SGclock_state};
            s_sync <= s_meta;
            s_prev <= s_sync;
            s_vld  <= {s_vld[1:0], 1'b1};
            // The zeros left by reset would otherwise look stable, so s_vld gates them out.
            if (s_vld[2] && (s_sync == s_prev)) begin
                s_stable <= s_sync;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Change detection
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sent <= 12'hFFF;
            pending   <= 1'b0;
        end else if (state == ST_LOAD) begin
            last_sent <= s_stable;
            pending   <= 1'b0;
        end else if (stall_hit || (s_stable != last_sent)) begin
            // A dropped frame is requested again.
            pending <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (pending && !rx_busy) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SEND;
            ST_SEND: begin
                if (stall_hit) begin
                    state_nxt = ST_IDLE;
                end else if (last_byte) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        siwu_n   = 1'b1;
        oe_n     = 1'b1;
        busy     = 1'b1;
        unique case (state)
            ST_IDLE:  busy = 1'b0;
            ST_LOAD:  ;
            ST_SEND: begin
                data_oe  = 1'b1;
                data_out = frame_b[byte_idx];
            end
            ST_FLUSH: siwu_n = 1'b0;
            default:  busy = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame buffer
    // -----------------------------------------------------------------------
    // NOTE: the frame bytes have no reset. They are read only in SEND, and
    // SEND is always entered through LOAD, which writes all four bytes.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            frame_b[0] <= HEADER;
            frame_b[1] <= {4'h0, s_stable[11:8]};
            frame_b[2] <= s_stable[7:0];
            frame_b[3] <= HEADER ^ {4'h0, s_stable[11:8]} ^ s_stable[7:0];
        end
    end

    // -----------------------------------------------------------------------
    // FIFO handshake, stall timer and frame counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx    <= 2'd0;
            stall_cnt   <= 16'd0;
            wr_n        <= 1'b1;
            tx_drop     <= 1'b0;
            frames_sent <= 8'h00;
        end else begin
            // The strobe follows FIFO-ready one cycle late. A stalled byte is
            // re-presented unchanged until an edge sees both signals low.
            wr_n <= !((state_nxt == ST_SEND) && !TXEn);
            // Registered, so the pulse coincides with the first IDLE cycle of the abort.
            tx_drop <= stall_hit;

            if (state == ST_LOAD) begin
                byte_idx  <= 2'd0;
                stall_cnt <= 16'd0;
            end else if (accept) begin
                byte_idx  <= byte_idx + 2'd1;
                stall_cnt <= 16'd0;
            end else if ((state == ST_SEND) && TXEn) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            if (last_byte) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_status_tx.sv
// ---------------------------------------------------------------------------
// tb_ftdi_status_tx
//
// Self-checking bench for ftdi_status_tx (TIMEOUT = 16). A monitor collects
// every byte the FIFO accepts and groups bytes into frames. The bench
// compares each frame against a reference frame built from the snapshot it
// applied. Directed scenarios are followed by a randomized phase with
// FIFO stalls and rx_busy pulses, which runs the frame counter up to 256.
// ---------------------------------------------------------------------------
module tb_ftdi_status_tx;

    localparam logic [7:0]  HDR = 8'hA5;
    localparam logic [15:0] TMO = 16'd16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] cs      = 4'h0;
    logic [3:0] ps      = 4'h0;
    logic [3:0] sg      = 4'h0;
    logic       rx_busy = 1'b0;
    logic       txe_n   = 1'b0;

    logic [7:0] data_out;
    logic       data_oe;
    logic       wr_n;
    logic       siwu_n;
    logic       oe_n;
    logic       busy;
    logic       tx_drop;
    logic [7:0] frames_sent;

    ftdi_status_tx #(
        .HEADER (HDR),
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .controlstate (cs),
        .psPot_state  (ps),
        .SGclock_state(sg),
        .rx_busy      (rx_busy),
        .TXEn         (txe_n),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .wr_n         (wr_n),
        .siwu_n       (siwu_n),
        .oe_n         (oe_n),
        .busy         (busy),
        .tx_drop      (tx_drop),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame for a 12-bit snapshot {controlstate, psPot, SGclock}.
    function automatic logic [31:0] exp_frame(input logic [11:0] s);
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = {4'h0, s[11:8]};
        b2 = s[7:0];
        return {HDR, b1, b2, HDR ^ b1 ^ b2};
    endfunction

    // ---------------------------------------------------------------------
    // Bus monitor: samples on the falling edge what the next rising edge will accept
    // ---------------------------------------------------------------------
    logic [31:0] frames[$];
    logic [7:0]  part[$];
    int acc_cnt    = 0;
    int siwu_cnt   = 0;
    int drop_cnt   = 0;
    int busy_cnt   = 0;
    int wr_low_cnt = 0;
    int bad_wr     = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            part.delete();
        end else begin
            if (tx_drop) begin
                drop_cnt++;
                part.delete();
            end
            if (!siwu_n) siwu_cnt++;
            if (busy) busy_cnt++;
            if (!wr_n) wr_low_cnt++;
            if (!wr_n && !data_oe) bad_wr++;
            if (!wr_n && !txe_n) begin
                acc_cnt++;
                part.push_back(data_out);
                if (part.size() == 4) begin
                    frames.push_back({part[0], part[1], part[2], part[3]});
                    part.delete();
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver helpers
    // ---------------------------------------------------------------------
    int          exp_total = 0;
    int          hi_run    = 0;
    int          base_acc;
    int          base_f;
    int          base_busy;
    int          base_wr;
    int          drop_at;
    int          stall_seen;
    int          lat;
    int          n_rand;
    int          k;
    logic [11:0] cur_s;
    logic [11:0] nxt_s;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s(input logic [11:0] s);
        {cs, ps, sg} = s;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int j = 0;
        while (frames.size() < n && j < budget) begin
            tick();
            j++;
        end
        check(tag, 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int j = 0;
        while (acc_cnt < n && j < budget) begin
            tick();
            j++;
        end
        check(tag, 32'(acc_cnt >= n), 32'd1);
    endtask

    // One cycle of random FIFO back-pressure (bursts capped well below TIMEOUT)
    // and occasional rx_busy.
    task automatic rand_tick();
        tick();
        if (hi_run < 3 && $urandom_range(0, 3) == 0) begin
            txe_n = 1'b1;
            hi_run++;
        end else begin
            txe_n  = 1'b0;
            hi_run = 0;
        end
        rx_busy = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        // Reset values
        set_s(12'h033);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_siwu_n", 32'(siwu_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_drop", 32'(tx_drop), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);

        // First frame after reset: 0/3/3 -> A5 00 33 96
        tick();
        reset_n = 1'b1;
        wait_frames(1, 60, "first_frame_arrived");
        exp_total = 1;
        check("first_frame_bytes", frames[0], 32'hA500_3396);
        repeat (6) tick();
        check("first_frame_siwu_cycles", 32'(siwu_cnt), 32'd1);
        check("first_frame_count", 32'(frames_sent), 32'd1);
        check("first_frame_single", 32'(frames.size()), 32'd1);

        // Stall of 5 cycles after B1: B2 is held, nothing lost or repeated
        base_acc = acc_cnt;
        set_s(12'h127);
        wait_bytes(base_acc + 2, 60, "stall_b1_accepted");
        txe_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wr_n", 32'(wr_n), 32'(i != 0));
            check("stall_data_held", 32'(data_out), 32'h27);
            tick();
        end
        txe_n = 1'b0;
        wait_frames(2, 40, "stall_frame_arrived");
        exp_total = 2;
        check("stall_frame_bytes", frames[1], 32'hA501_2783);
        check("stall_byte_total", 32'(acc_cnt - base_acc), 32'd4);

        // Snapshot change during a frame: old snapshot completes, then the new one follows
        base_f   = frames.size();
        base_acc = acc_cnt;
        set_s(12'h427);
        wait_bytes(base_acc + 1, 60, "midchg_header_accepted");
        set_s(12'h527);
        wait_frames(base_f + 2, 80, "midchg_frames_arrived");
        exp_total = 4;
        check("midchg_first", frames[base_f], exp_frame(12'h427));
        check("midchg_second", frames[base_f + 1], exp_frame(12'h527));
        check("midchg_count", 32'(frames_sent), 32'd4);

        // Timeout: FIFO stays full until the frame is dropped, then it is retried
        base_f   = frames.size();
        base_acc = acc_cnt;
        set_s(12'h5A3);
        wait_bytes(base_acc + 1, 60, "tmo_header_accepted");
        txe_n      = 1'b1;
        stall_seen = 0;
        drop_at    = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_drop) begin
                drop_at = stall_seen;
                check("tmo_data_oe", 32'(data_oe), 32'd0);
                check("tmo_wr_n", 32'(wr_n), 32'd1);
                check("tmo_count_held", 32'(frames_sent), 32'd4);
                break;
            end
            if (data_oe && txe_n) stall_seen++;
            tick();
        end
        check("tmo_stall_cycles", 32'(drop_at), 32'd16);
        tick();
        txe_n = 1'b0;
        @(negedge clk);
        check("tmo_pulse_width", 32'(tx_drop), 32'd0);
        wait_frames(base_f + 1, 60, "tmo_retry_arrived");
        exp_total = 5;
        check("tmo_retry_bytes", frames[base_f], exp_frame(12'h5A3));
        check("tmo_retry_count", 32'(frames_sent), 32'd5);

        // rx_busy holds off a pending frame; it starts within 2 cycles of release
        tick();
        rx_busy   = 1'b1;
        base_f    = frames.size();
        base_busy = busy_cnt;
        base_wr   = wr_low_cnt;
        set_s(12'h9C0);
        repeat (20) tick();
        check("rxb_no_busy", 32'(busy_cnt - base_busy), 32'd0);
        check("rxb_no_wr", 32'(wr_low_cnt - base_wr), 32'd0);
        rx_busy = 1'b0;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!busy && lat < 10);
        check("rxb_start_latency", 32'(lat <= 2), 32'd1);
        wait_frames(base_f + 1, 40, "rxb_frame_arrived");
        exp_total = 6;
        check("rxb_frame_bytes", frames[base_f], exp_frame(12'h9C0));

        // Input changing every cycle is never stable, so no frame is loaded until it settles
        repeat (8) tick();
        base_f    = frames.size();
        base_busy = busy_cnt;
        base_acc  = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            set_s((i % 2 == 0) ? 12'h2E1 : 12'h3E1);
            tick();
        end
        check("toggle_no_busy", 32'(busy_cnt - base_busy), 32'd0);
        check("toggle_no_bytes", 32'(acc_cnt - base_acc), 32'd0);
        set_s(12'h3E1);
        wait_frames(base_f + 1, 40, "toggle_settled_arrived");
        exp_total = 7;
        repeat (10) tick();
        check("toggle_settled_bytes", frames[base_f], exp_frame(12'h3E1));
        check("toggle_single_frame", 32'(frames.size() - base_f), 32'd1);

        // Random snapshots under random back-pressure, up to 256 frames since reset
        cur_s  = 12'h3E1;
        n_rand = 256 - exp_total;
        for (int f = 0; f < n_rand; f++) begin
            do nxt_s = 12'($urandom_range(0, 4094)); while (nxt_s == cur_s);
            cur_s = nxt_s;
            set_s(cur_s);
            k = 0;
            while (frames.size() < exp_total + 1 && k < 300) begin
                rand_tick();
                k++;
            end
            exp_total++;
            check("rand_frame_arrived", 32'(frames.size() >= exp_total), 32'd1);
            if (frames.size() >= exp_total) begin
                check("rand_frame_bytes", frames[exp_total - 1], exp_frame(cur_s));
            end
        end
        txe_n   = 1'b0;
        rx_busy = 1'b0;
        repeat (3) tick();
        check("wrap_frames_sent", 32'(frames_sent), 32'(exp_total % 256));

        // Reset in the middle of a frame aborts it; after release the snapshot is sent again
        base_f   = frames.size();
        base_acc = acc_cnt;
        set_s(12'h6B2);
        wait_bytes(base_acc + 1, 60, "midrst_header_accepted");
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_wr_n", 32'(wr_n), 32'd1);
        check("midrst_data_oe", 32'(data_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frames_sent", 32'(frames_sent), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        wait_frames(base_f + 1, 60, "midrst_frame_arrived");
        repeat (10) tick();
        check("midrst_frame_bytes", frames[base_f], exp_frame(12'h6B2));
        check("midrst_single_frame", 32'(frames.size() - base_f), 32'd1);
        check("midrst_count", 32'(frames_sent), 32'd1);

        // Whole-run properties
        check("wr_only_when_driving", 32'(bad_wr), 32'd0);
        check("drop_total", 32'(drop_cnt), 32'd1);
        check("oe_n_high", 32'(oe_n), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
